conv3x3_stream: RTL and testbench

- Sits directly downstream of ov7670_pixel_capture and consumes its write stream (addr, pixel, we) in the pclk domain.
- Converts each RGB444 pixel to 8-bit gray and keeps two line buffers to form a 3x3 window.
- Applies a selectable 3x3 kernel and emits a processed RGB444 pixel, with its frame-buffer address and write strobe, to the frame buffer.

---
 rtl/conv_pkg.sv | 36 +++
 rtl/line_buffer.sv | 34 +++
 rtl/conv3x3_stream.sv | 186 ++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution stream.
//   - default image geometry
//   - kernel selector encoding
//   - RGB444 -> 8-bit gray weights and conversion helper
//   - signed accumulator width and 0..255 clamp helper
package conv_pkg;

  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  // Weights sum to 16, so a full-scale nibble maps to 15*16 = 240.
  localparam int GW_R = 5;
  localparam int GW_G = 9;
  localparam int GW_B = 2;

  // Wide enough for the unnormalised gaussian sum (16 * 240 = 3840).
  localparam int ACC_W = 14;

  typedef enum logic [1:0] {
    K_PASS  = 2'd0,
    K_GAUSS = 2'd1,
    K_SHARP = 2'd2,
    K_SOBEL = 2'd3
  } kernel_e;

  function automatic logic [7:0] rgb444_to_gray(input logic [11:0] p);
    return 8'(int'(p[11:8]) * GW_R + int'(p[7:4]) * GW_G + int'(p[3:0]) * GW_B);
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] v);
    if (v < 0)        return 8'd0;
    else if (v > 255) return 8'd255;
    else              return v[7:0];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image line of 8-bit gray, single port, read-before-write.
//   clk_i    clock
//   we_i     access strobe (read and write happen together)
//   addr_i   column index
//   wdata_i  value stored at addr_i
//   peek_o   current content at addr_i (combinational, feeds a cascaded buffer)
//   rdata_o  content at addr_i before the write, registered on we_i
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    peek_o,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  assign peek_o  = mem_q[addr_i];
  assign rdata_o = rdata_q;

  // Storage is not reset; the consumer ignores reads until a frame has synced.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      rdata_q        <= mem_q[addr_i];
      mem_q[addr_i]  <= wdata_i;
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: gray 3x3 convolution on the camera capture write stream.
//   pclk, rst_n        pixel clock, async active-low reset
//   in_we/in_addr/in_pixel  capture stream (RGB444, linear index)
//   kernel_sel         0 pass, 1 gaussian, 2 sharpen, 3 sobel (latched at frame start)
//   out_we/out_addr/out_pixel  processed pixel for the window centre
//   frame_done         pulse with the last emitted pixel of a frame
// Pipeline: E0 capture + line buffer read, E1 window shift, E2 kernel into outputs.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PIX_W-1:0]  in_pixel,
  input  logic [1:0]        kernel_sel,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0]     COL_MAX = CW'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] K_FIRST = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_BOT = ADDR_W'(IMG_H);

  typedef struct packed {
    logic              emit;
    logic              border;
    logic              last;
    kernel_e           kern;
    logic [ADDR_W-1:0] addr;
  } meta_t;

  // ---------------- stream position ----------------
  logic              sync_q, sof, acc;
  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [ADDR_W-1:0] row_q, row_d, cur_row, idx_q, idx_d, cur_idx;
  kernel_e           kern_q, cur_kern;
  meta_t             meta_d;

  always_comb begin
    sof      = in_we && (in_addr == '0);
    acc      = in_we && (sync_q || sof);
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    cur_idx  = sof ? '0 : idx_q;
    cur_kern = sof ? kernel_e'(kernel_sel) : kern_q;
    col_d    = (cur_col == COL_MAX) ? '0 : cur_col + 1'b1;
    row_d    = (cur_col == COL_MAX) ? cur_row + 1'b1 : cur_row;
    idx_d    = cur_idx + 1'b1;
    // Centre is one row up and one column left of the incoming pixel, so
    // centre col 0 / IMG_W-1 maps to incoming col 1 / 0 and centre row
    // 0 / IMG_H-1 maps to incoming row 1 / IMG_H.
    meta_d.emit   = (cur_idx >= K_FIRST) && (cur_idx <= K_LAST);
    meta_d.border = (cur_col <= CW'(1)) || (cur_row == ADDR_W'(1)) || (cur_row == ROW_BOT);
    meta_d.last   = (cur_idx == K_LAST);
    meta_d.kern   = cur_kern;
    meta_d.addr   = cur_idx - K_FIRST;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      idx_q  <= '0;
      kern_q <= K_PASS;
    end else if (acc) begin
      sync_q <= 1'b1;
      col_q  <= col_d;
      row_q  <= row_d;
      idx_q  <= idx_d;
      kern_q <= cur_kern;
    end
  end

  // ---------------- line buffers ----------------
  logic [7:0] gray, lb0_peek, lb0_rd, lb1_rd, lb1_peek_unused;

  assign gray = rgb444_to_gray(in_pixel[11:0]);

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk_i(pclk), .we_i(acc), .addr_i(cur_col), .wdata_i(gray),
    .peek_o(lb0_peek), .rdata_o(lb0_rd)
  );

  // lb1 takes lb0's pre-write content at the same edge, so the two lines age together.
  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk_i(pclk), .we_i(acc), .addr_i(cur_col), .wdata_i(lb0_peek),
    .peek_o(lb1_peek_unused), .rdata_o(lb1_rd)
  );

  // ---------------- window pipeline ----------------
  logic [1:0]            vld_pipe;
  meta_t                 meta1_q, meta2_q;
  logic [7:0]            gray_q;
  logic [2:0][2:0][7:0]  win_q;   // [row][col], row 0 oldest, col 2 newest

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      meta1_q  <= '0;
      meta2_q  <= '0;
      gray_q   <= '0;
      win_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], acc};
      if (acc) begin
        meta1_q <= meta_d;
        gray_q  <= gray;
      end
      if (vld_pipe[0]) begin
        meta2_q <= meta1_q;
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_rd;
        win_q[1][2] <= lb0_rd;
        win_q[2][2] <= gray_q;
      end
    end
  end

  // ---------------- kernels ----------------
  logic signed [ACC_W-1:0] p [3][3];
  logic signed [ACC_W-1:0] gx, gy, ax, ay, kr;
  logic [7:0]              res;

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = $signed({{(ACC_W-8){1'b0}}, win_q[r][c]});
    gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (meta2_q.kern)
      K_PASS:  kr = p[1][1];
      K_GAUSS: kr = (p[0][0] + p[0][2] + p[2][0] + p[2][2]
                    + ((p[0][1] + p[1][0] + p[1][2] + p[2][1]) <<< 1)
                    + (p[1][1] <<< 2)) >>> 4;
      K_SHARP: kr = (p[1][1] <<< 2) + p[1][1] - p[0][1] - p[1][0] - p[1][2] - p[2][1];
      default: kr = ax + ay;
    endcase
    res = meta2_q.border ? 8'd0 : clamp8(kr);
  end

  // ---------------- outputs ----------------
  logic              out_we_q, frame_done_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [PIX_W-1:0]  out_pixel_q;
  logic              fire;

  assign fire = vld_pipe[1] && meta2_q.emit;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      out_addr_q   <= '0;
      out_pixel_q  <= '0;
    end else begin
      out_we_q     <= fire;
      frame_done_q <= fire && meta2_q.last;
      if (fire) begin
        out_addr_q  <= meta2_q.addr;
        out_pixel_q <= PIX_W'({res[7:4], res[7:4], res[7:4]});
      end
    end
  end

  assign out_we     = out_we_q;
  assign frame_done = frame_done_q;
  assign out_addr   = out_addr_q;
  assign out_pixel  = out_pixel_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
module tb_conv3x3_stream;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = 17;
  localparam int PW = 12;
  localparam int LAST_A = N - W - 2;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_we = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [PW-1:0] in_pixel = '0;
  logic [1:0]    kernel_sel = '0;
  logic          out_we, frame_done;
  logic [AW-1:0] out_addr;
  logic [PW-1:0] out_pixel;

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
    .pclk(pclk), .rst_n(rst_n), .in_we(in_we), .in_addr(in_addr),
    .in_pixel(in_pixel), .kernel_sel(kernel_sel), .out_we(out_we),
    .out_addr(out_addr), .out_pixel(out_pixel), .frame_done(frame_done)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct { int addr; int pix; int cyc; bit last; } exp_t;
  typedef struct { int pat; int kern; int a; int exp; } vec_t;

  exp_t        expq [$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          n_out_we = 0;
  logic [11:0] frm [N];
  int          got_pix [N];
  int          got_cnt [N];
  vec_t        vec [17];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gray_of(input logic [11:0] px);
    return int'(px[11:8]) * 5 + int'(px[7:4]) * 9 + int'(px[3:0]) * 2;
  endfunction

  function automatic int model_px(input int kern, input int a);
    int r, c, v, gx, gy;
    int g [3][3];
    r = a / W;
    c = a % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        g[i][j] = gray_of(frm[(r + i - 1) * W + c + j - 1]);
    gx = 0;
    gy = 0;
    case (kern)
      0: v = g[1][1];
      1: v = (g[0][0] + 2*g[0][1] + g[0][2] + 2*g[1][0] + 4*g[1][1] + 2*g[1][2]
              + g[2][0] + 2*g[2][1] + g[2][2]) / 16;
      2: v = 5*g[1][1] - g[0][1] - g[1][0] - g[1][2] - g[2][1];
      default: begin
        gx = (g[0][2] + 2*g[1][2] + g[2][2]) - (g[0][0] + 2*g[1][0] + g[2][0]);
        gy = (g[2][0] + 2*g[2][1] + g[2][2]) - (g[0][0] + 2*g[0][1] + g[0][2]);
        v  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      end
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return (v / 16) * 'h111;
  endfunction

  task automatic fill(input int pat);
    for (int k = 0; k < N; k++) begin
      case (pat)
        0: frm[k] = 12'hFFF;
        1: frm[k] = ((k % W) >= 4) ? 12'hFFF : 12'h000;
        2: frm[k] = (k == 2 * W + 3) ? 12'hFFF : 12'h000;
        default: frm[k] = 12'($urandom);
      endcase
    end
  endtask

  task automatic clear_got();
    for (int k = 0; k < N; k++) begin
      got_pix[k] = -1;
      got_cnt[k] = 0;
    end
  endtask

  // Sends addresses 0..n-1 every other pclk; kernel_sel changes to kern2 at k==sw_at.
  task automatic send_frame(input int n, input int kern, input int sw_at, input int kern2);
    for (int k = 0; k < n; k++) begin
      @(negedge pclk);
      if (k == 0) kernel_sel = 2'(kern);
      if (k == sw_at) kernel_sel = 2'(kern2);
      in_we    = 1'b1;
      in_addr  = AW'(k);
      in_pixel = frm[k];
      if (k >= W + 1) expq.push_back('{k - W - 1, model_px(kern, k - W - 1), cyc + 3, k == N - 1});
      @(negedge pclk);
      in_we = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (6) @(negedge pclk);
    chk("drain_queue_empty", expq.size(), 0);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge pclk) begin
    if (rst_n) begin
      if (frame_done && !out_we) chk("frame_done_without_we", 1, 0);
      if (out_we) begin
        n_out_we++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual addr=%0d required no out_we", out_addr);
        end else begin
          mon_e = expq.pop_front();
          chk("out_addr", int'(out_addr), mon_e.addr);
          chk("out_pixel", int'(out_pixel), mon_e.pix);
          chk("out_latency_cycle", cyc, mon_e.cyc);
          chk("frame_done", int'(frame_done), int'(mon_e.last));
        end
        if (int'(out_addr) < N) begin
          got_pix[out_addr] = int'(out_pixel);
          got_cnt[out_addr]++;
        end
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    vec[0]  = '{0, 0, 19, 'hFFF};
    vec[1]  = '{0, 0,  3, 'h000};
    vec[2]  = '{0, 0, 31, 'h000};
    vec[3]  = '{0, 0,  8, 'h000};
    vec[4]  = '{0, 1, 19, 'hFFF};
    vec[5]  = '{0, 1, 36, 'hFFF};
    vec[6]  = '{0, 3, 19, 'h000};
    vec[7]  = '{1, 3, 19, 'hFFF};
    vec[8]  = '{1, 3, 20, 'hFFF};
    vec[9]  = '{1, 3, 18, 'h000};
    vec[10] = '{1, 3, 21, 'h000};
    vec[11] = '{1, 3, 28, 'hFFF};
    vec[12] = '{2, 2, 19, 'hFFF};
    vec[13] = '{2, 2, 11, 'h000};
    vec[14] = '{2, 2, 18, 'h000};
    vec[15] = '{2, 2, 20, 'h000};
    vec[16] = '{2, 2, 27, 'h000};

    repeat (3) @(negedge pclk);
    chk("reset_out_we", int'(out_we), 0);
    chk("reset_out_addr", int'(out_addr), 0);
    chk("reset_out_pixel", int'(out_pixel), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;

    // Spot checks on known images.
    for (int i = 0; i < 17; i++) begin
      fill(vec[i].pat);
      clear_got();
      send_frame(N, vec[i].kern, -1, vec[i].kern);
      drain();
      chk($sformatf("vec%0d_pixel", i), got_pix[vec[i].a], vec[i].exp);
      chk($sformatf("vec%0d_once", i), got_cnt[vec[i].a], 1);
    end

    // Every centre address 0..LAST_A exactly once, trailing ones never.
    fill(0);
    clear_got();
    send_frame(N, 0, -1, 0);
    drain();
    for (int a = 0; a < N; a++)
      chk($sformatf("emit_count_a%0d", a), got_cnt[a], (a <= LAST_A) ? 1 : 0);

    // Random images under every kernel.
    for (int f = 0; f < 8; f++) begin
      fill(3);
      send_frame(N, f % 4, -1, f % 4);
      drain();
    end

    // Mid-frame kernel change only takes effect from the next frame.
    fill(3);
    send_frame(N, 0, 20, 3);
    fill(3);
    send_frame(N, 3, 5, 0);
    drain();

    // Mid-frame sync: restart from addr 0 after 20 inputs.
    fill(3);
    send_frame(20, 1, -1, 1);
    fill(3);
    send_frame(N, 2, -1, 2);
    drain();

    // Mid-frame reset: outputs clear at once; no output until the next sync pixel.
    fill(3);
    send_frame(30, 0, -1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_we", int'(out_we), 0);
    chk("midrst_out_addr", int'(out_addr), 0);
    chk("midrst_out_pixel", int'(out_pixel), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    expq.delete();
    @(negedge pclk);
    rst_n = 1'b1;
    n_out_we = 0;
    for (int k = 10; k < N; k++) begin
      @(negedge pclk);
      in_we    = 1'b1;
      in_addr  = AW'(k);
      in_pixel = 12'hFFF;
      @(negedge pclk);
      in_we = 1'b0;
    end
    repeat (6) @(negedge pclk);
    chk("no_out_without_sync", n_out_we, 0);

    // Recovery after the next sync pixel.
    fill(3);
    send_frame(N, 3, -1, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
